// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - coin sensor inputs and accepted-coin outputs of the coin acceptor
interface coin_acceptor_if #(
  parameter int CNT_W = 8
);
  logic             raw_quarter;
  logic             raw_dollar;
  logic             inhibit;
  logic             q_in;
  logic             d_in;
  logic             reject;
  logic             jam;
  logic [CNT_W-1:0] q_cnt;
  logic [CNT_W-1:0] d_cnt;

  modport master (
    output raw_quarter, raw_dollar, inhibit,
    input  q_in, d_in, reject, jam, q_cnt, d_cnt
  );

  modport slave (
    input  raw_quarter, raw_dollar, inhibit,
    output q_in, d_in, reject, jam, q_cnt, d_cnt
  );
endinterface

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - synchronise, debounce and validate quarter/dollar sensors
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst,
  coin_acceptor_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, PULSE, RELEASE, JAM} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             is_dollar, is_dollar_nx;
  logic             reject_r, reject_nx;
  logic [1:0]       q_sync, d_sync;
  logic [CNT_W-1:0] q_cnt_r, d_cnt_r;
  logic             s_q, s_d, lat, oth;

  assign s_q = q_sync[1];
  assign s_d = d_sync[1];
  assign lat = is_dollar ? s_d : s_q;
  assign oth = is_dollar ? s_q : s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sync    <= 2'b00;
      d_sync    <= 2'b00;
      state     <= IDLE;
      cnt       <= '0;
      is_dollar <= 1'b0;
      reject_r  <= 1'b0;
      q_cnt_r   <= '0;
      d_cnt_r   <= '0;
    end else begin
      q_sync    <= {q_sync[0], bus.raw_quarter};
      d_sync    <= {d_sync[0], bus.raw_dollar};
      state     <= state_nx;
      cnt       <= cnt_nx;
      is_dollar <= is_dollar_nx;
      reject_r  <= reject_nx;
      if (state == PULSE && !is_dollar && q_cnt_r != '1)
        q_cnt_r <= q_cnt_r + 1'b1;
      if (state == PULSE && is_dollar && d_cnt_r != '1)
        d_cnt_r <= d_cnt_r + 1'b1;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    is_dollar_nx = is_dollar;
    reject_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (s_q && s_d) begin
          state_nx = JAM;
          cnt_nx   = '0;
        end else if (s_q ^ s_d) begin
          cnt_nx = '0;
          if (bus.inhibit) begin
            reject_nx = 1'b1;
            state_nx  = RELEASE;
          end else begin
            is_dollar_nx = s_d;
            state_nx     = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!lat) begin
          state_nx = IDLE;
        end else if (oth) begin
          state_nx = JAM;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx = PULSE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PULSE: begin
        state_nx = RELEASE;
        cnt_nx   = '0;
      end
      RELEASE, JAM: begin
        // Any activity on either line restarts the quiet-time window.
        if (s_q || s_d) begin
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign bus.q_in   = (state == PULSE) && !is_dollar;
  assign bus.d_in   = (state == PULSE) && is_dollar;
  assign bus.reject = reject_r;
  assign bus.jam    = (state == JAM);
  assign bus.q_cnt  = q_cnt_r;
  assign bus.d_cnt  = d_cnt_r;
endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed self-checking bench for coin_acceptor
module tb_coin_acceptor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int q_pulses = 0;
  int d_pulses = 0;
  int rej_pulses = 0;
  int both_hi = 0;

  coin_acceptor_if #(.CNT_W(8)) bus ();

  coin_acceptor #(.DEBOUNCE(4), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.q_in === 1'b1) q_pulses++;
    if (bus.d_in === 1'b1) d_pulses++;
    if (bus.reject === 1'b1) rej_pulses++;
    if (bus.q_in === 1'b1 && bus.d_in === 1'b1) both_hi++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic quarter();
    bus.raw_quarter = 1'b1;
    cycles(10);
    bus.raw_quarter = 1'b0;
    cycles(10);
  endtask

  initial begin
    bus.raw_quarter = 1'b0;
    bus.raw_dollar  = 1'b0;
    bus.inhibit     = 1'b0;
    cycles(2);
    chk("rst_q_in", int'(bus.q_in), 0);
    chk("rst_d_in", int'(bus.d_in), 0);
    chk("rst_reject", int'(bus.reject), 0);
    chk("rst_jam", int'(bus.jam), 0);
    chk("rst_q_cnt", int'(bus.q_cnt), 0);
    chk("rst_d_cnt", int'(bus.d_cnt), 0);
    rst = 1'b0;
    cycles(2);

    // T1: steady quarter, pulse in the cycle after edge 7
    bus.raw_quarter = 1'b1;
    cycles(6);
    chk("t1_before_edge7", int'(bus.q_in), 0);
    cycles(1);
    chk("t1_after_edge7", int'(bus.q_in), 1);
    chk("t1_no_d_in", int'(bus.d_in), 0);
    cycles(1);
    chk("t1_single_cycle", int'(bus.q_in), 0);
    cycles(12);
    bus.raw_quarter = 1'b0;
    cycles(10);
    chk("t1_q_pulses", q_pulses, 1);
    chk("t1_q_cnt", int'(bus.q_cnt), 1);
    chk("t1_d_pulses", d_pulses, 0);

    // T2: bouncing dollar then steady
    bus.raw_dollar = 1'b1; cycles(1);
    bus.raw_dollar = 1'b0; cycles(1);
    bus.raw_dollar = 1'b1; cycles(1);
    bus.raw_dollar = 1'b0; cycles(1);
    bus.raw_dollar = 1'b1; cycles(20);
    bus.raw_dollar = 1'b0; cycles(10);
    chk("t2_d_pulses", d_pulses, 1);
    chk("t2_d_cnt", int'(bus.d_cnt), 1);
    chk("t2_q_pulses", q_pulses, 1);

    // T3: 3-cycle glitch is dropped, next quarter has full-latency acceptance
    bus.raw_quarter = 1'b1; cycles(3);
    bus.raw_quarter = 1'b0; cycles(10);
    chk("t3_q_pulses", q_pulses, 1);
    chk("t3_q_cnt", int'(bus.q_cnt), 1);
    bus.raw_quarter = 1'b1;
    cycles(7);
    chk("t3_idle_latency", int'(bus.q_in), 1);
    cycles(10);
    bus.raw_quarter = 1'b0;
    cycles(10);
    chk("t3_q_cnt_after", int'(bus.q_cnt), 2);

    // T4: both lines together -> jam, then recovery
    bus.raw_quarter = 1'b1;
    bus.raw_dollar  = 1'b1;
    cycles(5);
    chk("t4_jam_set", int'(bus.jam), 1);
    cycles(10);
    chk("t4_jam_held", int'(bus.jam), 1);
    chk("t4_no_q", q_pulses, 2);
    chk("t4_no_d", d_pulses, 1);
    bus.raw_quarter = 1'b0;
    bus.raw_dollar  = 1'b0;
    cycles(10);
    chk("t4_jam_clear", int'(bus.jam), 0);
    quarter();
    chk("t4_q_cnt_after", int'(bus.q_cnt), 3);

    // T5: inhibited insertion is rejected and not re-accepted while held
    bus.inhibit = 1'b1;
    bus.raw_quarter = 1'b1;
    cycles(6);
    chk("t5_reject", rej_pulses, 1);
    bus.inhibit = 1'b0;
    cycles(10);
    chk("t5_no_q_held", q_pulses, 3);
    chk("t5_q_cnt_held", int'(bus.q_cnt), 3);
    bus.raw_quarter = 1'b0;
    cycles(10);
    quarter();
    chk("t5_reassert_q", q_pulses, 4);
    chk("t5_reject_once", rej_pulses, 1);

    // T6: saturation
    for (int i = 0; i < 256; i++) quarter();
    chk("t6_q_cnt_sat", int'(bus.q_cnt), 255);
    chk("t6_q_pulses", q_pulses, 260);
    chk("t6_d_cnt", int'(bus.d_cnt), 1);
    chk("never_both", both_hi, 0);

    // Reset while a quarter is in SETTLE
    bus.raw_quarter = 1'b1;
    cycles(4);
    rst = 1'b1;
    #1;
    chk("mid_rst_q_in", int'(bus.q_in), 0);
    chk("mid_rst_jam", int'(bus.jam), 0);
    chk("mid_rst_q_cnt", int'(bus.q_cnt), 0);
    chk("mid_rst_d_cnt", int'(bus.d_cnt), 0);
    bus.raw_quarter = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(12);
    chk("mid_rst_no_pulse", q_pulses, 260);
    chk("mid_rst_q_cnt_after", int'(bus.q_cnt), 0);
    chk("mid_rst_reject", rej_pulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
